parity_check_fifo: RTL and testbench

- Second-generation parity-protected FIFO with a valid/grant handshake on both the push and pop sides.
- Every word is checked for parity when it is pushed, not when it is popped.
- Bad words are either tagged and forwarded, or dropped, selected by parameter.
- Exposes an error pulse, a saturating error counter and the FIFO fill level, for use by a stimulus/receiver pair or by upstream link logic.

---
 rtl/parity_fifo_pkg.sv | 24 ++
 rtl/parity_fifo_mem.sv | 58 +++++
 rtl/parity_check_fifo.sv | 91 +++++++++
 tb/tb_parity_check_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_fifo_pkg.sv
// Shared parity types and the parity check used by the FIFO and by any receiver-side checker.
// Pure combinational helpers; no latency, no backpressure.
package parity_fifo_pkg;

  typedef enum logic {ERR_PASS, ERR_DROP} err_mode_e;
  typedef enum logic {PAR_MSB, PAR_LSB} parity_sel_e;

  localparam int PAR_MAX_W = 257;

  // word holds DATA_WIDTH+1 valid bits (zero-extended); dw is the payload width.
  function automatic logic parity_ok(input logic [PAR_MAX_W-1:0] word,
                                     input int                   dw,
                                     input logic                 even_odd,
                                     input parity_sel_e          sel);
    logic [PAR_MAX_W-1:0] mask;
    logic                 all_x;
    logic                 pbit;
    mask  = {PAR_MAX_W{1'b1}} >> (PAR_MAX_W - 1 - dw);
    all_x = ^(word & mask);
    pbit  = (sel == PAR_MSB) ? word[dw[8:0]] : word[0];
    return pbit == (all_x ^ pbit ^ even_odd);
  endfunction

endpackage

// File: rtl/parity_fifo_mem.sv
// Circular storage with head/tail pointers and a separate occupancy counter; any depth >= 2.
// Latency: write visible at head one cycle later; backpressure: writes ignored when full, reads when empty.
module parity_fifo_mem #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_wr;
  logic          do_rd;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[head];

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (do_wr) tail <= ptr_next(tail);
      if (do_rd) head <= ptr_next(head);
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/parity_check_fifo.sv
// Parity-checking FIFO: checks at push, tags or drops bad words, counts errors. Optional macro PARITY_CHECK_FIFO_REGEN_EN regenerates parity on data_o.
// Latency: 1-cycle fall-through, no push-to-pop bypass; backpressure: grant_o low while full (even if popping).
module parity_check_fifo
  import parity_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0,
  parameter int ERR_MODE   = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH:0]              data_i,
  input  logic                             valid_i,
  output logic                             grant_o,
  output logic [DATA_WIDTH:0]              data_o,
  output logic                             valid_o,
  input  logic                             grant_i,
  output logic                             perr_o,
  output logic                             err_o,
  output logic [CNT_WIDTH-1:0]             err_cnt_o,
  input  logic                             clr_err_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o
);

  localparam int  EW       = DATA_WIDTH + 2;
  localparam bit  DROP_BAD = (ERR_MODE == int'(ERR_DROP));
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic          bad;
  logic          push_hs;
  logic          bad_hs;
  logic          wr_en;
  logic          rd_en;
  logic          full;
  logic          empty;
  logic [EW-1:0] head;

  assign bad     = !parity_ok(PAR_MAX_W'(data_i), DATA_WIDTH, 1'(EVEN_ODD),
                              parity_sel_e'(PARITY_BIT[0]));
  assign grant_o = !full;
  assign push_hs = valid_i && grant_o;
  assign bad_hs  = push_hs && bad;
  // In drop mode a bad word still completes its handshake but never reaches storage.
  assign wr_en   = push_hs && !(DROP_BAD && bad);
  assign valid_o = !empty;
  assign rd_en   = valid_o && grant_i;
  assign perr_o  = valid_o && head[EW-1] && !DROP_BAD;

  parity_fifo_mem #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_dat ({bad, data_i}),
    .rd_en  (rd_en),
    .rd_dat (head),
    .full   (full),
    .empty  (empty),
    .level  (level_o)
  );

  always_comb begin
    data_o = head[DATA_WIDTH:0];
`ifdef PARITY_CHECK_FIFO_REGEN_EN
    if (PARITY_BIT == int'(PAR_MSB))
      data_o[DATA_WIDTH] = ^head[DATA_WIDTH-1:0] ^ 1'(EVEN_ODD);
    else
      data_o[0] = ^head[DATA_WIDTH:1] ^ 1'(EVEN_ODD);
`endif
  end

  // Clear wins over increment, but a coincident bad push still lands as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o <= bad_hs;
      if (clr_err_i)
        err_cnt_o <= bad_hs ? CNT_WIDTH'(1) : '0;
      else if (bad_hs && err_cnt_o != CNT_MAX)
        err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_check_fifo.sv
// Scoreboard bench: instance A (depth 4, pass mode, 2-bit counter), instance B (depth 3, drop mode).
module tb_parity_check_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_dat(input logic [8:0] w);
    logic [8:0] r;
    r = w;
`ifdef PARITY_CHECK_FIFO_REGEN_EN
    r[8] = ^w[7:0];
`endif
    return r;
  endfunction

  // ---------------- instance A ----------------
  logic [8:0] a_din = '0, a_dout;
  logic a_vin = 0, a_gin = 0, a_clr = 0, a_gout, a_vout, a_perr, a_err;
  logic [1:0] a_cnt;
  logic [2:0] a_lvl;

  parity_check_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .EVEN_ODD(0), .PARITY_BIT(0),
                      .ERR_MODE(0), .CNT_WIDTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_i(a_din), .valid_i(a_vin), .grant_o(a_gout),
    .data_o(a_dout), .valid_o(a_vout), .grant_i(a_gin), .perr_o(a_perr), .err_o(a_err),
    .err_cnt_o(a_cnt), .clr_err_i(a_clr), .level_o(a_lvl));

  // ---------------- instance B ----------------
  logic [8:0] b_din = '0, b_dout;
  logic b_vin = 0, b_gin = 0, b_clr = 0, b_gout, b_vout, b_perr, b_err;
  logic [7:0] b_cnt;
  logic [1:0] b_lvl;

  parity_check_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(3), .EVEN_ODD(0), .PARITY_BIT(0),
                      .ERR_MODE(1), .CNT_WIDTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_i(b_din), .valid_i(b_vin), .grant_o(b_gout),
    .data_o(b_dout), .valid_o(b_vout), .grant_i(b_gin), .perr_o(b_perr), .err_o(b_err),
    .err_cnt_o(b_cnt), .clr_err_i(b_clr), .level_o(b_lvl));

  // Scoreboards: {bad_flag, word}
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic       a_err_exp = 0, b_err_exp = 0;
  int         a_cnt_exp = 0, b_cnt_exp = 0;

  always @(negedge clk) begin
    if (rst_n) begin : mon_a
      int lvl; logic bad, hs; logic [9:0] e;
      lvl = qa.size();
      chk("a_level", 32'(a_lvl), 32'(lvl));
      chk("a_valid", 32'(a_vout), 32'(lvl != 0));
      chk("a_grant", 32'(a_gout), 32'(lvl < 4));
      chk("a_err", 32'(a_err), 32'(a_err_exp));
      chk("a_cnt", 32'(a_cnt), 32'(a_cnt_exp));
      if (a_vout && a_gin) begin
        if (qa.size() == 0) chk("a_pop_empty", 32'(a_vout), 32'(0));
        else begin
          e = qa.pop_front();
          chk("a_data", 32'(a_dout), 32'(exp_dat(e[8:0])));
          chk("a_perr", 32'(a_perr), 32'(e[9]));
        end
      end
      bad = (^a_din) != 1'b0;
      hs  = a_vin && (lvl < 4);
      if (hs) qa.push_back({bad, a_din});
      a_err_exp = hs && bad;
      if (a_clr) a_cnt_exp = (hs && bad) ? 1 : 0;
      else if (hs && bad && a_cnt_exp < 3) a_cnt_exp++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin : mon_b
      int lvl; logic bad, hs; logic [9:0] e;
      lvl = qb.size();
      chk("b_level", 32'(b_lvl), 32'(lvl));
      chk("b_valid", 32'(b_vout), 32'(lvl != 0));
      chk("b_grant", 32'(b_gout), 32'(lvl < 3));
      chk("b_err", 32'(b_err), 32'(b_err_exp));
      chk("b_cnt", 32'(b_cnt), 32'(b_cnt_exp));
      if (b_vout && b_gin) begin
        if (qb.size() == 0) chk("b_pop_empty", 32'(b_vout), 32'(0));
        else begin
          e = qb.pop_front();
          chk("b_data", 32'(b_dout), 32'(exp_dat(e[8:0])));
          chk("b_perr", 32'(b_perr), 32'(0));
        end
      end
      bad = (^b_din) != 1'b0;
      hs  = b_vin && (lvl < 3);
      if (hs && !bad) qb.push_back({1'b0, b_din});
      b_err_exp = hs && bad;
      if (b_clr) b_cnt_exp = (hs && bad) ? 1 : 0;
      else if (hs && bad && b_cnt_exp < 255) b_cnt_exp++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    a_err_exp = 0; b_err_exp = 0;
    a_cnt_exp = 0; b_cnt_exp = 0;
  endtask

  logic [8:0] fill_vec [5];
  logic [8:0] w;

  initial begin
    fill_vec[0] = 9'h003; fill_vec[1] = 9'h107; fill_vec[2] = 9'h00F;
    fill_vec[3] = 9'h000; fill_vec[4] = 9'h00C;

    #1 rst_n = 1'b0;
    #10;
    chk("rst_a_valid", 32'(a_vout), 0);
    chk("rst_a_grant", 32'(a_gout), 1);
    chk("rst_a_level", 32'(a_lvl), 0);
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_a_cnt", 32'(a_cnt), 0);
    chk("rst_a_perr", 32'(a_perr), 0);
    chk("rst_b_valid", 32'(b_vout), 0);
    chk("rst_b_grant", 32'(b_gout), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill A to full with the receiver stalled; 5th push must be ignored.
    for (int i = 0; i < 5; i++) begin
      a_din = fill_vec[i]; a_vin = 1'b1;
      tick();
      if (i < 4) chk("a_fill_level", 32'(a_lvl), 32'(i + 1));
    end
    a_vin = 1'b0;
    chk("a_full_grant", 32'(a_gout), 0);
    chk("a_full_level", 32'(a_lvl), 4);
    a_gin = 1'b1;
    tick(5);
    chk("a_drained_valid", 32'(a_vout), 0);
    a_gin = 1'b0;

    // Single bad word in pass mode.
    a_din = 9'h103; a_vin = 1'b1;
    tick();
    a_vin = 1'b0;
    chk("a_err_pulse", 32'(a_err), 1);
    chk("a_bad_perr", 32'(a_perr), 1);
    tick();
    chk("a_err_fall", 32'(a_err), 0);
    chk("a_cnt_one", 32'(a_cnt), 1);
    a_gin = 1'b1;
    tick(2);

    // Saturate the 2-bit counter, then clear alongside a bad push.
    for (int i = 0; i < 5; i++) begin
      a_din = (i % 2 == 0) ? 9'h001 : 9'h103; a_vin = 1'b1;
      tick();
    end
    a_vin = 1'b0;
    tick();
    chk("a_cnt_sat", 32'(a_cnt), 3);
    a_clr = 1'b1; a_din = 9'h001; a_vin = 1'b1;
    tick();
    a_clr = 1'b0; a_vin = 1'b0;
    chk("a_clr_bad", 32'(a_cnt), 1);
    tick(3);
    a_gin = 1'b0;

    // Drop mode on B: bad word accepted, not stored.
    b_din = 9'h103; b_vin = 1'b1;
    tick();
    b_din = 9'h003;
    tick();
    b_vin = 1'b0;
    chk("b_drop_level", 32'(b_lvl), 1);
    chk("b_drop_cnt", 32'(b_cnt), 1);
    chk("b_drop_head", 32'(b_dout), 32'(exp_dat(9'h003)));
    b_gin = 1'b1;
    tick(2);

    // Stream 10 good words through depth-3 B across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      w[7:0] = 8'(i * 37 + 5);
      w[8]   = ^w[7:0];
      b_din = w; b_vin = 1'b1;
      tick();
      chk("b_stream_level", 32'(b_lvl), 1);
    end
    b_vin = 1'b0;
    tick(3);
    b_gin = 1'b0;
    chk("b_stream_empty", 32'(b_vout), 0);

    // Asynchronous reset with two words held in A.
    a_din = 9'h0AA; a_vin = 1'b1;
    tick();
    a_din = 9'h003;
    tick();
    a_vin = 1'b0;
    chk("a_pre_rst_level", 32'(a_lvl), 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_valid", 32'(a_vout), 0);
    chk("mrst_level", 32'(a_lvl), 0);
    chk("mrst_grant", 32'(a_gout), 1);
    tick();
    rst_n = 1'b1;
    a_din = 9'h0AA; a_vin = 1'b1;
    tick();
    a_vin = 1'b0;
    chk("post_rst_head", 32'(a_dout), 32'(exp_dat(9'h0AA)));
    a_gin = 1'b1;
    tick(2);
    a_gin = 1'b0;
    chk("post_rst_empty", 32'(a_vout), 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
